uart_tx_frame_ctrl: RTL
=======================

Name: uart_tx_frame_ctrl

Overview:
Transmit-frame sequencer for the uart_16550 TX path. It accepts one data word per handshake and presents the word to the parity generator. It then serialises start, data (LSB first), optional parity and 1 or 2 stop bits on o_txd, pacing each bit by an oversampled baud-tick strobe. It owns the parity generator's inputs and samples its registered output.

Parameters:
data_length, 8, data bits per frame (5..8).
OVERSAMPLE, 16, i_baud_tick strobes per serial bit (>=2).

Ports:
i_sys_clk  input  1  system clock, all logic on rising edge.
i_sys_rst_n  input  1  synchronous reset, active-low.
i_baud_tick  input  1  one-cycle strobe, OVERSAMPLE per bit period.
i_data  input  data_length  word to transmit.
i_valid  input  1  i_data valid; transfer on i_valid & o_ready.
o_ready  output  1  block can accept a word.
i_parity_en  input  1  1 = insert parity bit.
i_parity_type  input  1  passed to parity generator.
i_stop2  input  1  1 = two stop bits, 0 = one.
o_par_data  output  data_length  latched word to parity generator.
o_par_type  output  1  latched parity type to parity generator.
i_parity  input  1  parity generator result (registered, 1-cycle latency).
o_txd  output  1  serial line, idle high.
o_busy  output  1  frame in progress.
o_done  output  1  one-cycle pulse at end of last stop bit.

Behaviour:
- Reset (i_sys_clk edge with i_sys_rst_n=0): state IDLE, o_txd=1, o_ready=1, o_busy=0, o_done=0, o_par_data=0, o_par_type=0, tick/bit counters=0. Reset applies mid-frame: the frame is aborted and the line returns high on that edge.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_ready=1, o_busy=0, o_txd=1.
- Accept when i_valid & o_ready at edge N:
  - latch i_data into shift reg and o_par_data;
  - latch i_parity_type into o_par_type;
  - latch i_parity_en and i_stop2;
  - clear tick counter;
  - enter START.
  - From N+1: o_txd=0, o_ready=0, o_busy=1.
- Config inputs are ignored outside the accept cycle. Changing them mid-frame has no effect.
- Bit timing: tick counter increments on each i_baud_tick. The bit ends on the tick that brings the count to OVERSAMPLE; the counter then clears and the next state/bit drives o_txd from the following cycle. Cycles without i_baud_tick hold everything.
- START -> DATA after OVERSAMPLE ticks.
- DATA: o_txd = shift reg bit 0. Shift right at each bit end. Bit counter runs 0..data_length-1. After the last bit, go to PARITY if parity enabled, otherwise STOP.
- PARITY: o_txd = i_parity, registered on entry to PARITY and held for the bit. i_parity is guaranteed settled because o_par_data has been stable since N+1.
- STOP: o_txd=1 for OVERSAMPLE ticks, or 2*OVERSAMPLE ticks if the latched i_stop2=1.
- On the final tick of STOP, the next cycle: o_done=1 for exactly one cycle, state IDLE, o_ready=1, o_busy=0.
- A new accept is allowed in the o_done cycle. Back-to-back frames have no idle gap beyond that cycle.
- Frame length in ticks: OVERSAMPLE * (1 + data_length + parity_en + 1 + stop2).
- i_valid while busy: ignored; the word is held by the source until o_ready.
- i_baud_tick coincident with accept: not counted toward the start bit. The start bit counts ticks from N+1 onward.

Test Plan:
- i_baud_tick every cycle, 0xA5, parity off, 1 stop -> o_txd bit sequence 0,1,0,1,0,0,1,0,1,1, each 16 cycles. 160 cycles total, o_done at cycle N+161.
- 0xA5 with parity on, bench parity model i_parity = ^data ^ type -> type=0 gives parity bit 0; type=1 gives bit 1. Frame is 176 cycles.
- 0x0F, parity on, i_stop2=1, i_baud_tick every 3rd cycle -> stop high for 32 ticks (96 cycles). o_busy spans 12 bits; config toggled mid-frame has no effect.
- Two words (0x55 then 0xC3) with i_valid held -> second accepted in the o_done cycle. The second start bit begins the cycle after, and no extra idle bits appear.
- Reset asserted during DATA bit 3 -> next edge o_txd=1, o_busy=0, o_ready=1, no o_done. A fresh frame then transmits correctly.
- i_valid asserted while busy with different data -> ignored, and the current frame bits are unchanged.

Source files
------------

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: start, data LSB-first, opt parity, 1/2 stop.
// Ports: sys clk/rst_n, baud tick, valid/ready word in, parity gen io, txd.
module uart_tx_frame_ctrl #(
  parameter int data_length = 8,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst_n,
  input  logic                   i_baud_tick,
  input  logic [data_length-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_parity_en,
  input  logic                   i_parity_type,
  input  logic                   i_stop2,
  output logic [data_length-1:0] o_par_data,
  output logic                   o_par_type,
  input  logic                   i_parity,
  output logic                   o_txd,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(data_length);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(data_length - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [data_length-1:0] shreg;
  logic                   par_en_q;
  logic                   stop2_q;
  logic                   par_bit;
  logic                   done_nxt;
  logic                   accept;
  logic                   bit_end;
  logic                   data_last;

  assign o_ready   = (state == IDLE);
  assign o_busy    = (state != IDLE);
  assign accept    = i_valid & o_ready;
  assign bit_end   = i_baud_tick & (tick_cnt == TICK_LAST);
  assign data_last = (bit_cnt == BIT_LAST);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_valid) state_nxt = START;
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end && data_last)
          state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        // second stop bit tracked through bit_cnt
        if (bit_end && (!stop2_q || bit_cnt[0])) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_txd = 1'b1;
    unique case (state)
      START:   o_txd = 1'b0;
      DATA:    o_txd = shreg[0];
      PARITY:  o_txd = par_bit;
      default: o_txd = 1'b1;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state      <= IDLE;
      o_done     <= 1'b0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      o_par_data <= '0;
      o_par_type <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      par_bit    <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_done <= done_nxt;
      if (accept) begin
        shreg      <= i_data;
        o_par_data <= i_data;
        o_par_type <= i_parity_type;
        par_en_q   <= i_parity_en;
        stop2_q    <= i_stop2;
        tick_cnt   <= '0;
        bit_cnt    <= '0;
      end else if (o_busy && i_baud_tick) begin
        tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
        if (bit_end) begin
          if (state == DATA) begin
            shreg   <= {1'b0, shreg[data_length-1:1]};
            bit_cnt <= data_last ? '0 : bit_cnt + BW'(1);
            if (data_last && par_en_q) par_bit <= i_parity;
          end else if (state == STOP) begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
      end
    end
  end

endmodule
